// File: rtl/snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snake_dir_ctrl
// Brief    : Turns four raw active-low buttons into a queued snake direction.
//            Optional macro SNAKE_DIR_REVERSE_FILTER_EN drops 180-deg reversals.
// Revision : 1.0 - initial release
// ============================================================================
module snake_dir_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         FIFO_DEPTH      = 2,
    parameter logic [1:0] INIT_DIR        = 2'b10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    key_n,
    input  logic                          move_ack,
    input  logic                          clear,
    output logic [1:0]                    dir,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          q_full,
    output logic                          drop
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt1    = (c_ptr_w + 1)'(1);

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_stable;
    logic [3:0] r_stable_d;
    logic [3:0] r_press;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= 4'b0000;
            r_sync2    <= 4'b0000;
            r_stable_d <= 4'b0000;
            r_press    <= 4'b0000;
        end else begin
            r_sync1    <= ~key_n;
            r_sync2    <= r_sync1;
            r_stable_d <= w_stable;
            r_press    <= w_stable & ~r_stable_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_stable;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (r_sync2[gi] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_stable <= r_sync2[gi];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end

        assign w_stable[gi] = r_stable;
    end

    // Key index doubles as the direction code; lowest index wins a tie.
    logic       w_cand_vld;
    logic [1:0] w_cand;

    always_comb begin
        w_cand_vld = |r_press;
        w_cand     = 2'b11;
        if (r_press[0])      w_cand = 2'b00;
        else if (r_press[1]) w_cand = 2'b01;
        else if (r_press[2]) w_cand = 2'b10;
    end

    logic [1:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic [1:0]         r_dir;
    logic               r_full;
    logic               r_drop;

    logic [c_ptr_w-1:0] w_tail_idx;
    logic [1:0]         w_ref;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_rev;
    logic [c_ptr_w:0]   w_count_nxt;

    assign w_tail_idx = r_wr_ptr - c_ptr_one;
    assign w_ref      = (r_count != '0) ? r_mem[w_tail_idx] : r_dir;
    assign w_pop      = move_ack && (r_count != '0);

    always_comb begin
        w_push = 1'b0;
        w_drop = 1'b0;
        w_rev  = 1'b0;
`ifdef SNAKE_DIR_REVERSE_FILTER_EN
        w_rev  = (w_cand == (w_ref ^ 2'b11));
`endif
        if (w_cand_vld && (w_cand != w_ref)) begin
            if (w_rev)
                w_drop = 1'b1;
            else if ((r_count == c_depth) && !w_pop)
                w_drop = 1'b1;
            else
                w_push = 1'b1;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + c_cnt1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - c_cnt1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dir    <= INIT_DIR;
            r_full   <= 1'b0;
            r_drop   <= 1'b0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dir    <= INIT_DIR;
            r_full   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_drop  <= w_drop;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop) begin
                r_dir    <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Storage needs no reset: entries are only read while r_count is non-zero.
    always_ff @(posedge clk) begin
        if (rst_n && !clear && w_push)
            r_mem[r_wr_ptr] <= w_cand;
    end

    assign dir     = r_dir;
    assign pending = r_count;
    assign q_full  = r_full;
    assign drop    = r_drop;

endmodule
`default_nettype wire
